// File: rtl/encoder_speed_sampler.sv
// Quadrature encoder front end: decodes A/B into signed 4x steps and reports one speed sample per WINDOW clocks.
// Optional ENC_GLITCH_FILTER_EN adds a 3-sample stability filter on each synchronized channel.
//
// state  | meaning
// S_FILL | synchronizer/filter still filling after reset; no decode
// S_RUN  | decoder armed; prev vs AB compared every cycle
module encoder_speed_sampler #(
    parameter int WINDOW = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enc_a,
    input  logic               enc_b,
    output logic signed [31:0] speed_out,
    output logic               speed_valid,
    output logic               dir_meas,
    output logic               enc_err
);

    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

    typedef enum logic {S_FILL, S_RUN} arm_state_t;

    arm_state_t         state, state_nxt;
    logic [2:0]         arm_cnt;
    logic [1:0]         ab_m, ab_s, ab, prev;
    logic signed [1:0]  step, delta_q;
    logic               bad;
    logic [31:0]        acc, acc_sat;
    logic [32:0]        acc_ext;
    logic [WCNT_W-1:0]  wcnt;
    logic               terminal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_m <= 2'b00;
            ab_s <= 2'b00;
        end else begin
            ab_m <= {enc_a, enc_b};
            ab_s <= ab_m;
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam logic [2:0] ARM_LAST = 3'd5;
    logic [1:0] hist0, hist1, ab_f;

    // A bit follows the synchronizer only once three consecutive samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0 <= 2'b00;
            hist1 <= 2'b00;
            ab_f  <= 2'b00;
        end else begin
            hist0 <= ab_s;
            hist1 <= hist0;
            for (int i = 0; i < 2; i++) begin
                if (ab_s[i] == hist0[i] && hist0[i] == hist1[i])
                    ab_f[i] <= ab_s[i];
            end
        end
    end

    assign ab = ab_f;
`else
    localparam logic [2:0] ARM_LAST = 3'd2;
    assign ab = ab_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FILL;
            arm_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == S_FILL)
                arm_cnt <= arm_cnt + 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_FILL && arm_cnt == ARM_LAST)
            state_nxt = S_RUN;
    end

    always_comb begin
        step = 2'sb00;
        bad  = 1'b0;
        if (state == S_RUN) begin
            case ({prev, ab})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = 2'sb01;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = 2'sb11;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad  = 1'b1;
                default: ;
            endcase
        end
    end

    // prev tracks AB every cycle, so on arming it already holds the live value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= 2'b00;
            delta_q <= 2'sb00;
            enc_err <= 1'b0;
        end else begin
            prev    <= ab;
            delta_q <= step;
            enc_err <= bad;
        end
    end

    assign acc_ext = {acc[31], acc} + {{31{delta_q[1]}}, delta_q};

    always_comb begin
        acc_sat = acc_ext[31:0];
        if (acc_ext[32] != acc_ext[31])
            acc_sat = acc_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    assign terminal = (wcnt == WCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            acc         <= 32'd0;
            speed_out   <= 32'sd0;
            dir_meas    <= 1'b0;
            speed_valid <= 1'b0;
        end else begin
            speed_valid <= terminal;
            if (terminal) begin
                wcnt      <= '0;
                acc       <= 32'd0;
                speed_out <= acc_sat;
                dir_meas  <= acc_sat[31];
            end else begin
                wcnt <= wcnt + WCNT_W'(1);
                acc  <= acc_sat;
            end
        end
    end

endmodule

// File: tb/tb_encoder_speed_sampler.sv
// Self-checking bench for encoder_speed_sampler: directed window scenarios plus randomized pin activity
// compared every cycle against a pin-history reference model.
module tb_encoder_speed_sampler;

    localparam int W = 100;
`ifdef ENC_GLITCH_FILTER_EN
    localparam int ARM = 6;
`else
    localparam int ARM = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic signed [31:0] speed_out;
    logic speed_valid, dir_meas, enc_err;

    encoder_speed_sampler #(.WINDOW(W)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .speed_out(speed_out), .speed_valid(speed_valid),
        .dir_meas(dir_meas), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: k counts rising edges since reset release.
    int k = 0;
    logic [1:0] last_samp = 2'b00;
    logic [1:0] in1 = 2'b00, in2 = 2'b00;
    logic [1:0] h1 = 2'b00, h2 = 2'b00, h3 = 2'b00, filt = 2'b00;
    logic [1:0] m_ab, m_din;
    longint win = 0;
    int pend = 0;
    int m_d;
    longint exp_speed = 0;
    bit exp_valid = 0, exp_dir = 0, exp_err = 0;

    function automatic int pos(input logic [1:0] v);
        case (v)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; last_samp = 2'b00; in1 = 2'b00; in2 = 2'b00;
            h1 = 2'b00; h2 = 2'b00; h3 = 2'b00; filt = 2'b00;
            win = 0; pend = 0; exp_speed = 0;
            exp_valid = 0; exp_dir = 0; exp_err = 0;
        end else begin
            k++;
            m_ab = last_samp;
            last_samp = {enc_a, enc_b};
`ifdef ENC_GLITCH_FILTER_EN
            for (int i = 0; i < 2; i++)
                if (h1[i] == h2[i] && h2[i] == h3[i]) filt[i] = h1[i];
            m_din = filt;
            h3 = h2; h2 = h1; h1 = m_ab;
`else
            m_din = m_ab;
`endif
            win = win + pend;
            if (win > 64'sd2147483647) win = 64'sd2147483647;
            if (win < -64'sd2147483648) win = -64'sd2147483648;
            exp_valid = (k % W == 0);
            if (exp_valid) begin
                exp_speed = win;
                exp_dir = (win < 0);
                win = 0;
            end
            pend = 0;
            exp_err = 0;
            if (k >= ARM + 1) begin
                m_d = (pos(in1) - pos(in2) + 4) % 4;
                if (m_d == 1) pend = 1;
                else if (m_d == 3) pend = -1;
                else if (m_d == 2) exp_err = 1;
            end
            in2 = in1;
            in1 = m_din;
        end
    end

    int nvalid = 0, nerr = 0, valid_k = 0;
    longint last_speed = 0;
    bit last_dir = 0;

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("speed_valid", speed_valid, exp_valid);
            check("enc_err", enc_err, exp_err);
            check("speed_out", speed_out, exp_speed);
            check("dir_meas", dir_meas, exp_dir);
            if (speed_valid) begin
                nvalid++;
                valid_k = k;
                last_speed = speed_out;
                last_dir = dir_meas;
            end
            if (enc_err) nerr++;
        end
    end

    int cur_pos = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic move(input int d);
        logic [1:0] c;
        cur_pos = (cur_pos + d + 8) % 4;
        case (cur_pos)
            0: c = 2'b00;
            1: c = 2'b10;
            2: c = 2'b11;
            default: c = 2'b01;
        endcase
        enc_a = c[1];
        enc_b = c[0];
    endtask

    task automatic wait_valid(input string name, input int budget);
        int start;
        int i;
        start = nvalid;
        i = 0;
        while (nvalid == start && i < budget) begin
            tick();
            i++;
        end
        if (nvalid == start) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_k(input int target);
        int i;
        i = 0;
        while (k < target && i < 2 * W) begin
            tick();
            i++;
        end
        if (k != target) check("wait_k_timeout", k, target);
    endtask

    task automatic do_reset(input int len);
        rst_n = 1'b0;
        ticks(len);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, seen, r, hold;
        tick();
        tick();
        check("reset_speed_out", speed_out, 0);
        check("reset_valid", speed_valid, 0);
        check("reset_dir", dir_meas, 0);
        check("reset_err", enc_err, 0);
        tick();
        rst_n = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ticks(10);
            move(1);
        end
        wait_valid("fwd", 2 * W);
        check("first_valid_cycle", valid_k, 100);
        check("fwd_speed", last_speed, 4);
        check("fwd_dir", last_dir, 0);
        tick();
        check("valid_width", speed_valid, 0);

        for (int i = 0; i < 10; i++) begin
            ticks(5);
            move(-1);
        end
        wait_valid("rev", 2 * W);
        check("rev_speed", last_speed, -10);
        check("rev_dir", last_dir, 1);
        wait_valid("idle", 2 * W);
        check("idle_speed", last_speed, 0);
        check("idle_dir", last_dir, 0);

        e0 = nerr;
        ticks(10);
        move(2);
        ticks(10);
        move(1);
        wait_valid("illegal", 2 * W);
        check("illegal_err_count", nerr - e0, 1);
        check("illegal_speed", last_speed, 1);

        wait_k(496);
        move(1);
        wait_valid("term", 2 * W);
        check("term_step_speed", last_speed, 1);
        check("term_valid_cycle", valid_k, 500);
        wait_valid("term_next", 2 * W);
        check("term_next_speed", last_speed, 0);

        wait_k(697);
        move(1);
        wait_valid("late", 2 * W);
        check("late_step_closing", last_speed, 0);
        wait_valid("late_next", 2 * W);
        check("late_step_next", last_speed, 1);

        for (int i = 0; i < 3; i++) begin
            ticks(8);
            move(1);
        end
        wait_valid("pre_rst", 2 * W);
        check("pre_rst_speed", last_speed, 3);
        for (int i = 0; i < 7; i++) begin
            ticks(5);
            move(1);
        end
        wait_k(950);
        rst_n = 1'b0;
        #1;
        check("midrst_speed_out", speed_out, 0);
        check("midrst_valid", speed_valid, 0);
        check("midrst_dir", dir_meas, 0);
        check("midrst_err", enc_err, 0);
        ticks(3);
        rst_n = 1'b1;
        seen = nvalid;
        ticks(99);
        check("no_early_valid", nvalid - seen, 0);
        wait_valid("post_rst", 5);
        check("post_rst_valid_cycle", valid_k, 100);
        check("post_rst_speed", last_speed, 0);

        e0 = nerr;
        ticks(10);
        enc_a = ~enc_a;
        tick();
        enc_a = ~enc_a;
        wait_valid("glitch", 2 * W);
        check("glitch_speed", last_speed, 0);
        check("glitch_err_count", nerr - e0, 0);

        for (int it = 0; it < 700; it++) begin
            hold = $urandom_range(1, 8);
            ticks(hold);
            r = $urandom_range(0, 19);
            if (r == 0) move(2);
            else if (r < 12) move(1);
            else if (r < 19) move(-1);
            if (it == 350) do_reset($urandom_range(1, 4));
        end
        wait_valid("rand_tail", 2 * W);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
